// File: rtl/pic_pkg.sv
// Shared types and constants for the pic interrupt-acknowledge path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pic_pkg;

    // Sequencer states, in the order a normal acknowledge walks them.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACK1      = 3'd1,
        GAP       = 3'd2,
        ACK2      = 3'd3,
        DELIVER   = 3'd4,
        INSERVICE = 3'd5,
        EOI_WR    = 3'd6
    } pic_state_e;

    // Register-bus select codes.
    localparam logic [1:0] PIC_CMD_SELECT = 2'd0;
    localparam logic [1:0] PIC_VEC_SELECT = 2'd1;

    // Command bytes understood by the pic; the sequencer only issues EOI.
    localparam logic [7:0] PIC_EOI_CMD       = 8'h20;
    localparam logic [7:0] PIC_SPEC_EOI_BASE = 8'h60;
    localparam logic [7:0] PIC_READ_IRR      = 8'h0A;
    localparam logic [7:0] PIC_READ_ISR      = 8'h0B;

    // Width of every pulse/gap counter.
    localparam int PIC_CNT_W = 4;

    // Counter load value for a phase lasting 'cycles' clocks.
    function automatic logic [PIC_CNT_W-1:0] pic_cnt_load(input int cycles);
        return PIC_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/pic_ack_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level.
// Latency: STAGES clocks from d_i to q_o.
// Backpressure: none; free-running.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $fatal(1, "sync_bit: STAGES must be 1..3");
    end

    logic [STAGES-1:0] sync_q;

    // Shift the input through the chain; all flops clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pic_ack_sequencer.sv
// CPU-side pic controller: two-pulse intack, vector read/handoff, EOI write.
// Latency: int_in to intack SYNC_STAGES+2 clocks; ACK1/GAP/ACK2 then vector.
// Backpressure: vector held in DELIVER until vec_ready; EOI waits on eoi_req.
module pic_ack_sequencer
    import pic_pkg::*;
#(
    parameter int         ACK_CYCLES  = 2,
    parameter int         GAP_CYCLES  = 1,
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] VEC_SELECT  = PIC_VEC_SELECT,
    parameter logic [1:0] CMD_SELECT  = PIC_CMD_SELECT,
    parameter logic [7:0] EOI_CMD     = PIC_EOI_CMD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_in,
    input  logic       irq_enable,
    output logic       intack,
    output logic [1:0] pic_select,
    output logic       pic_readwrite,
    output logic       pic_oe,
    output logic [7:0] pic_wdata,
    input  logic [7:0] pic_rdata,
    output logic [7:0] vec,
    output logic       vec_valid,
    input  logic       vec_ready,
    input  logic       eoi_req,
    output logic       eoi_done,
    output logic       spurious,
    output logic       busy
);

    if (ACK_CYCLES < 1 || ACK_CYCLES > 15) begin : g_bad_ack
        $fatal(1, "pic_ack_sequencer: ACK_CYCLES must be 1..15");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $fatal(1, "pic_ack_sequencer: GAP_CYCLES must be 1..15");
    end
    if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
        $fatal(1, "pic_ack_sequencer: SYNC_STAGES must be 1..3");
    end

    localparam logic [PIC_CNT_W-1:0] ACK_LOAD = pic_cnt_load(ACK_CYCLES);
    localparam logic [PIC_CNT_W-1:0] GAP_LOAD = pic_cnt_load(GAP_CYCLES);

    logic int_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (int_in),
        .q_o   (int_s)
    );

    pic_state_e           state_q;
    logic [PIC_CNT_W-1:0] cnt_q;
    logic                 go_q;
    logic                 intack_q;
    logic [1:0]           select_q;
    logic                 readwrite_q;
    logic                 oe_q;
    logic [7:0]           wdata_q;
    logic [7:0]           vec_q;
    logic                 vec_valid_q;
    logic                 eoi_done_q;
    logic                 spurious_q;
    logic                 busy_q;

    // Sequencer FSM; every output is a flop loaded alongside the state so
    // outputs always describe the state being entered.  go_q registers the
    // IDLE start decision so the launch is one clean clock after int_s.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            go_q        <= 1'b0;
            intack_q    <= 1'b0;
            select_q    <= 2'd0;
            readwrite_q <= 1'b1;
            oe_q        <= 1'b0;
            wdata_q     <= 8'h00;
            vec_q       <= 8'h00;
            vec_valid_q <= 1'b0;
            eoi_done_q  <= 1'b0;
            spurious_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            eoi_done_q <= 1'b0;
            spurious_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go_q) begin
                        go_q     <= 1'b0;
                        state_q  <= ACK1;
                        cnt_q    <= ACK_LOAD;
                        intack_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        go_q <= int_s & irq_enable;
                    end
                end
                ACK1: begin
                    if (!int_s) begin
                        // Request withdrawn before the pic latched it.
                        state_q    <= IDLE;
                        intack_q   <= 1'b0;
                        busy_q     <= 1'b0;
                        spurious_q <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q  <= GAP;
                        cnt_q    <= GAP_LOAD;
                        intack_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q  <= ACK2;
                        cnt_q    <= ACK_LOAD;
                        intack_q <= 1'b1;
                        select_q <= VEC_SELECT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ACK2: begin
                    if (cnt_q == '0) begin
                        // Last pulse cycle: the pic is driving the vector now.
                        state_q     <= DELIVER;
                        vec_q       <= pic_rdata;
                        vec_valid_q <= 1'b1;
                        intack_q    <= 1'b0;
                        select_q    <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DELIVER: begin
                    if (vec_ready) begin
                        state_q     <= INSERVICE;
                        vec_valid_q <= 1'b0;
                    end
                end
                INSERVICE: begin
                    if (eoi_req) begin
                        state_q     <= EOI_WR;
                        oe_q        <= 1'b1;
                        readwrite_q <= 1'b0;
                        select_q    <= CMD_SELECT;
                        wdata_q     <= EOI_CMD;
                    end
                end
                EOI_WR: begin
                    state_q     <= IDLE;
                    oe_q        <= 1'b0;
                    readwrite_q <= 1'b1;
                    select_q    <= 2'd0;
                    wdata_q     <= 8'h00;
                    eoi_done_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    intack_q    <= 1'b0;
                    select_q    <= 2'd0;
                    readwrite_q <= 1'b1;
                    oe_q        <= 1'b0;
                    wdata_q     <= 8'h00;
                    vec_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign intack        = intack_q;
    assign pic_select    = select_q;
    assign pic_readwrite = readwrite_q;
    assign pic_oe        = oe_q;
    assign pic_wdata     = wdata_q;
    assign vec           = vec_q;
    assign vec_valid     = vec_valid_q;
    assign eoi_done      = eoi_done_q;
    assign spurious      = spurious_q;
    assign busy          = busy_q;

endmodule
